commit_unit: RTL and testbench
==============================

COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 Parameter OP_W, default 8: width of op field; SHALL equal the `AluOpBus` width from defines.v.
REQ-002 Port clk  input  1  single clock; all state on rising edge.
REQ-003 Port rst  input  1  asynchronous active-low reset.
REQ-004 Port commit_valid  input  1  ROB head is ready.
REQ-005 Ports commit_id/commit_op/commit_rd  input  `ROB_ID_WIDTH`/OP_W/5  head ROB id, op, destination register.
REQ-006 Ports commit_value/commit_pc/commit_addr/commit_pred_target  input  32 each  result, PC, store address or branch target, predicted target.
REQ-007 Ports commit_pred/commit_outcome  input  1 each  predicted-taken, actual-taken.
REQ-008 Port commit_ack  output  1  retire head this cycle.
REQ-009 Ports rf_we/rf_waddr/rf_wdata/rf_wrob_id  output  1/5/32/`ROB_ID_WIDTH`  architectural register write; rf_wrob_id clears the rename tag on match.
REQ-010 Ports mem_req/mem_addr/mem_wdata/mem_wmask  output  1/32/32/4  store request to memory controller.
REQ-011 Port mem_done  input  1  store accepted and complete.
REQ-012 Ports flush_o/redirect_pc  output  1/32  global flush and fetch redirect target.

Function
REQ-013 States SHALL be IDLE, STORE_WAIT, FLUSH; reset state IDLE.
REQ-014 Op classes, decoded from defines.v ops: STORE (SB/SH/SW), BRANCH (BEQ..BGEU), JUMP (JAL/JALR), OTHER.
REQ-015 IDLE & commit_valid & class != STORE: commit_ack=1 in the same cycle (combinational); rf_we=1 iff commit_rd != 0, rf_wdata=commit_value, rf_wrob_id=commit_id.
REQ-016 Mispredict = (commit_outcome != commit_pred) | (commit_outcome & commit_addr != commit_pred_target), evaluated only for BRANCH/JUMP.
REQ-017 On mispredicted commit: ack and RF write as REQ-015; next state FLUSH; redirect_pc registered = commit_outcome ? commit_addr : commit_pc+4.
REQ-018 FLUSH: flush_o=1 for exactly one cycle; commit_ack=0, rf_we=0; next state IDLE.
REQ-019 IDLE & commit_valid & STORE: commit_ack=0; register mem_addr=commit_addr, mem_wdata=commit_value shifted to byte lane commit_addr[1:0], mem_wmask (SB 0001<<a[1:0], SH 0011<<{a[1],0}, SW 1111); enter STORE_WAIT.
REQ-020 STORE_WAIT: mem_req=1 and mem_addr/wdata/wmask held stable until mem_done; on the mem_done cycle commit_ack=1, rf_we=0, next state IDLE; mem_req deasserts on the following edge.
REQ-021 Misaligned SH/SW addresses SHALL be masked (address bits below access size forced to 0); no exception.
REQ-022 commit_valid low: no ack, no writes, state unchanged.
REQ-023 At most one retirement per cycle; commit_ack never asserted without commit_valid.

Reset
REQ-024 rst low SHALL asynchronously force state=IDLE and mem_req, flush_o, commit_ack, rf_we = 0, redirect_pc = 0, mem_addr/wdata/wmask = 0; an in-flight store is abandoned.
REQ-025 First retirement possible on the first edge after rst rises.

Configuration
REQ-026 Macro COMMIT_PERF_EN: when defined, adds outputs perf_retired[63:0] (+1 per commit_ack) and perf_mispred[31:0] (+1 per FLUSH entry), both reset to 0, wrapping; when undefined the ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-027 Op codes, class decode constants and state encodings SHALL live in defines.v/params.v; no new literals in the module.
REQ-028 One sub-module, store_align, SHALL compute mem_wdata/mem_wmask combinationally from op, addr[1:0], value.

Verification
REQ-029 ADD rd=5 value 0x11 id 3 -> same cycle commit_ack=1, rf_we=1, rf_waddr=5, rf_wdata=0x11, rf_wrob_id=3.
REQ-030 OTHER with rd=0 -> commit_ack=1, rf_we=0.
REQ-031 SB addr 0x1003 value 0xAB, mem_done after 3 cycles -> mem_req high 3 cycles, wmask 1000, wdata 0xAB000000, ack only in mem_done cycle.
REQ-032 BEQ pc 0x100 pred=1 outcome=0 -> ack, next cycle flush_o=1 one cycle, redirect_pc=0x104.
REQ-033 JALR rd=1 pred_target 0x200 addr 0x240 outcome=1 -> rf write rd=1, flush_o, redirect_pc=0x240; with COMMIT_PERF_EN perf_mispred=1.
REQ-034 rst low during STORE_WAIT -> mem_req drops immediately, state IDLE, no ack.

Source files
------------

// File: rtl/commit_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : commit_unit_pkg
// Brief   : Op codes, op-class decode, state encoding and store helpers
//           shared by the commit unit and its store aligner.
// Revision: 1.0 - initial release
// ============================================================================
package commit_unit_pkg;

  localparam int ROB_ID_WIDTH = 4;
  localparam int OP_BUS_W     = 8;

  // Op codes carried on the ALU op bus
  localparam logic [OP_BUS_W-1:0] OP_ADD  = 8'h01;
  localparam logic [OP_BUS_W-1:0] OP_SB   = 8'h10;
  localparam logic [OP_BUS_W-1:0] OP_SH   = 8'h11;
  localparam logic [OP_BUS_W-1:0] OP_SW   = 8'h12;
  localparam logic [OP_BUS_W-1:0] OP_BEQ  = 8'h20;
  localparam logic [OP_BUS_W-1:0] OP_BNE  = 8'h21;
  localparam logic [OP_BUS_W-1:0] OP_BLT  = 8'h22;
  localparam logic [OP_BUS_W-1:0] OP_BGE  = 8'h23;
  localparam logic [OP_BUS_W-1:0] OP_BLTU = 8'h24;
  localparam logic [OP_BUS_W-1:0] OP_BGEU = 8'h25;
  localparam logic [OP_BUS_W-1:0] OP_JAL  = 8'h30;
  localparam logic [OP_BUS_W-1:0] OP_JALR = 8'h31;

  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [3:0]  WMASK_B      = 4'b0001;
  localparam logic [3:0]  WMASK_H      = 4'b0011;
  localparam logic [3:0]  WMASK_W      = 4'b1111;
  localparam logic [31:0] ADDR_ALIGN_H = 32'hFFFF_FFFE;
  localparam logic [31:0] ADDR_ALIGN_W = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    CLS_OTHER  = 2'd0,
    CLS_STORE  = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_JUMP   = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } state_e;

  function automatic op_class_e op_class(input logic [OP_BUS_W-1:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW:                               op_class = CLS_STORE;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:  op_class = CLS_BRANCH;
      OP_JAL, OP_JALR:                                   op_class = CLS_JUMP;
      default:                                           op_class = CLS_OTHER;
    endcase
  endfunction

  // Misaligned halfword/word stores are silently aligned down
  function automatic logic [31:0] store_addr(input logic [OP_BUS_W-1:0] op,
                                             input logic [31:0] addr);
    case (op)
      OP_SH:   store_addr = addr & ADDR_ALIGN_H;
      OP_SW:   store_addr = addr & ADDR_ALIGN_W;
      default: store_addr = addr;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/commit_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : commit_unit_if
// Brief   : ROB-head commit bus, register-file write port, store port and
//           flush/redirect outputs of the commit unit.
// Revision: 1.0 - initial release
// ============================================================================
interface commit_unit_if
  import commit_unit_pkg::*;
#(
  parameter int OP_W = OP_BUS_W
) ();

  logic                    commit_valid;
  logic [ROB_ID_WIDTH-1:0] commit_id;
  logic [OP_W-1:0]         commit_op;
  logic [4:0]              commit_rd;
  logic [31:0]             commit_value;
  logic [31:0]             commit_pc;
  logic [31:0]             commit_addr;
  logic [31:0]             commit_pred_target;
  logic                    commit_pred;
  logic                    commit_outcome;
  logic                    commit_ack;

  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [31:0]             rf_wdata;
  logic [ROB_ID_WIDTH-1:0] rf_wrob_id;

  logic                    mem_req;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_wmask;
  logic                    mem_done;

  logic                    flush_o;
  logic [31:0]             redirect_pc;

  // Environment side: ROB head and memory controller
  modport master (
    output commit_valid, commit_id, commit_op, commit_rd, commit_value,
           commit_pc, commit_addr, commit_pred_target, commit_pred,
           commit_outcome, mem_done,
    input  commit_ack, rf_we, rf_waddr, rf_wdata, rf_wrob_id,
           mem_req, mem_addr, mem_wdata, mem_wmask, flush_o, redirect_pc
  );

  // Commit unit side
  modport slave (
    input  commit_valid, commit_id, commit_op, commit_rd, commit_value,
           commit_pc, commit_addr, commit_pred_target, commit_pred,
           commit_outcome, mem_done,
    output commit_ack, rf_we, rf_waddr, rf_wdata, rf_wrob_id,
           mem_req, mem_addr, mem_wdata, mem_wmask, flush_o, redirect_pc
  );

endinterface
`default_nettype wire

// File: rtl/commit_unit_store_align.sv
`default_nettype none
// ============================================================================
// Module  : store_align
// Brief   : Places store data on its byte lanes and builds the write mask
//           from the store op and the low address bits.
// Revision: 1.0 - initial release
// ============================================================================
module store_align
  import commit_unit_pkg::*;
#(
  parameter int OP_W = OP_BUS_W
) (
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     value,
  output logic [31:0]     wdata,
  output logic [3:0]      wmask
);

  // Lane steering; halfwords use only addr_lo[1] so misaligned SH lands aligned
  always_comb begin
    wdata = value;
    wmask = WMASK_W;
    case (op)
      OP_SB: begin
        wdata = {24'd0, value[7:0]} << {addr_lo, 3'b000};
        wmask = WMASK_B << addr_lo;
      end
      OP_SH: begin
        wdata = {16'd0, value[15:0]} << {addr_lo[1], 4'b0000};
        wmask = WMASK_H << {addr_lo[1], 1'b0};
      end
      default: begin
        wdata = value;
        wmask = WMASK_W;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : commit_unit
// Brief   : Retires the ROB head: register writes, stores via a request/done
//           handshake, and a one-cycle flush with fetch redirect on branch or
//           jump mispredict.
// Options : COMMIT_PERF_EN adds perf_retired / perf_mispred counters.
// Revision: 1.0 - initial release
// ============================================================================
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int OP_W = OP_BUS_W
) (
  input  logic         clk,
  input  logic         rst,
  commit_unit_if.slave bus
`ifdef COMMIT_PERF_EN
  ,
  output logic [63:0]  perf_retired,
  output logic [31:0]  perf_mispred
`endif
);

  state_e      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;

  logic        commit_ack;
  logic        rf_we;
  logic        mem_req;
  logic        flush_o;

  op_class_e   op_cls;
  logic        is_ctrl;
  logic        mispredict;
  logic [31:0] align_wdata;
  logic [3:0]  align_wmask;

  store_align #(.OP_W(OP_W)) u_store_align (
    .op      (bus.commit_op),
    .addr_lo (bus.commit_addr[1:0]),
    .value   (bus.commit_value),
    .wdata   (align_wdata),
    .wmask   (align_wmask)
  );

  // Op classification and mispredict detection for the current head
  always_comb begin
    op_cls     = op_class(bus.commit_op);
    is_ctrl    = (op_cls == CLS_BRANCH) || (op_cls == CLS_JUMP);
    mispredict = is_ctrl &&
                 ((bus.commit_outcome != bus.commit_pred) ||
                  (bus.commit_outcome && (bus.commit_addr != bus.commit_pred_target)));
  end

  // Next state, retirement handshake and register/store datapath.
  // Retirement in IDLE is gated by rst so nothing retires while reset is held.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wmask_d   = mem_wmask_q;
    commit_ack    = 1'b0;
    rf_we         = 1'b0;
    mem_req       = 1'b0;
    flush_o       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rst && bus.commit_valid) begin
          if (op_cls == CLS_STORE) begin
            mem_addr_d  = store_addr(bus.commit_op, bus.commit_addr);
            mem_wdata_d = align_wdata;
            mem_wmask_d = align_wmask;
            state_d     = ST_STORE_WAIT;
          end else begin
            commit_ack = 1'b1;
            rf_we      = (bus.commit_rd != REG_ZERO);
            if (mispredict) begin
              state_d       = ST_FLUSH;
              redirect_pc_d = bus.commit_outcome ? bus.commit_addr
                                                 : bus.commit_pc + PC_STEP;
            end
          end
        end
      end
      ST_STORE_WAIT: begin
        mem_req = 1'b1;
        if (bus.mem_done) begin
          commit_ack = bus.commit_valid;
          state_d    = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and held store/redirect registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wmask_q   <= mem_wmask_d;
    end
  end

  assign bus.commit_ack  = commit_ack;
  assign bus.rf_we       = rf_we;
  assign bus.rf_waddr    = bus.commit_rd;
  assign bus.rf_wdata    = bus.commit_value;
  assign bus.rf_wrob_id  = bus.commit_id;
  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wmask   = mem_wmask_q;
  assign bus.flush_o     = flush_o;
  assign bus.redirect_pc = redirect_pc_q;

`ifdef COMMIT_PERF_EN
  logic [63:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;

  // Retire and flush-entry counters, free-running and wrapping
  always_comb begin
    perf_retired_d = perf_retired_q + 64'(commit_ack);
    perf_mispred_d = perf_mispred_q +
                     32'((state_q == ST_IDLE) && (state_d == ST_FLUSH));
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_retired_q <= '0;
      perf_mispred_q <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_mispred = perf_mispred_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_commit_unit
// Brief   : Self-checking bench for commit_unit; retirements are predicted
//           into a scoreboard queue and matched on every commit_ack.
// Revision: 1.0 - initial release
// ============================================================================
module tb_commit_unit;
  import commit_unit_pkg::*;

  typedef struct {
    logic                    we;
    logic [4:0]              waddr;
    logic [31:0]             wdata;
    logic [ROB_ID_WIDTH-1:0] id;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   n_retire;
  int   n_mis;
  exp_t sb[$];

  commit_unit_if #(.OP_W(8)) bus ();

`ifdef COMMIT_PERF_EN
  logic [63:0] perf_retired;
  logic [31:0] perf_mispred;
`endif

  commit_unit #(.OP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef COMMIT_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_mispred (perf_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] op, input logic [3:0] id, input logic [4:0] rd,
                       input logic [31:0] val, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] pt, input logic pred, input logic outc);
    bus.commit_valid       = 1'b1;
    bus.commit_op          = op;
    bus.commit_id          = id;
    bus.commit_rd          = rd;
    bus.commit_value       = val;
    bus.commit_pc          = pc;
    bus.commit_addr        = addr;
    bus.commit_pred_target = pt;
    bus.commit_pred        = pred;
    bus.commit_outcome     = outc;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] val,
                          input logic [3:0] id);
    exp_t e;
    e.we = we; e.waddr = rd; e.wdata = val; e.id = id;
    sb.push_back(e);
    n_retire++;
  endtask

  // Every retirement must match the oldest predicted one
  always @(negedge clk) begin
    if (bus.commit_ack === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_valid", bus.commit_valid, 1);
        chk("rf_we", bus.rf_we, e.we);
        if (e.we) begin
          chk("rf_waddr", bus.rf_waddr, e.waddr);
          chk("rf_wdata", bus.rf_wdata, e.wdata);
          chk("rf_wrob_id", bus.rf_wrob_id, e.id);
        end
      end
    end
  end

  task automatic do_store(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] val,
                          input logic [31:0] e_addr, input logic [31:0] e_wdata,
                          input logic [3:0] e_wmask, input int n);
    next_slot();
    drive(op, 4'd6, 5'd0, val, 32'h0, addr, 32'h0, 1'b0, 1'b0);
    sample();
    chk("st_idle_ack", bus.commit_ack, 0);
    for (int i = 0; i < n; i++) begin
      next_slot();
      bus.mem_done = (i == n - 1);
      if (i == n - 1) push_exp(1'b0, 5'd0, val, 4'd6);
      sample();
      chk("st_req", bus.mem_req, 1);
      chk("st_addr", bus.mem_addr, e_addr);
      chk("st_wdata", bus.mem_wdata, e_wdata);
      chk("st_wmask", bus.mem_wmask, e_wmask);
    end
    next_slot();
    bus.mem_done     = 1'b0;
    bus.commit_valid = 1'b0;
    sample();
    chk("st_req_drop", bus.mem_req, 0);
  endtask

  task automatic do_branch(input logic [7:0] op, input logic [4:0] rd, input logic [31:0] val,
                           input logic [3:0] id, input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] pt, input logic pred, input logic outc,
                           input logic e_flush, input logic [31:0] e_redir);
    next_slot();
    drive(op, id, rd, val, pc, addr, pt, pred, outc);
    push_exp(rd != 5'd0, rd, val, id);
    if (e_flush) n_mis++;
    sample();
    chk("br_ack", bus.commit_ack, 1);
    // Following instruction is presented immediately; it must wait out a flush
    next_slot();
    drive(OP_ADD, id + 4'd1, 5'd7, 32'h77, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    if (!e_flush) push_exp(1'b1, 5'd7, 32'h77, id + 4'd1);
    sample();
    chk("br_flush", bus.flush_o, e_flush);
    if (e_flush) begin
      chk("br_redirect", bus.redirect_pc, e_redir);
      chk("br_flush_ack", bus.commit_ack, 0);
      chk("br_flush_we", bus.rf_we, 0);
      next_slot();
      push_exp(1'b1, 5'd7, 32'h77, id + 4'd1);
      sample();
      chk("br_flush_drop", bus.flush_o, 0);
    end
    next_slot();
    bus.commit_valid = 1'b0;
    sample();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_retire = 0; n_mis = 0;
    bus.mem_done = 1'b0;
    rst = 1'b0;
    // ADD held valid through reset: nothing may retire until rst rises
    drive(OP_ADD, 4'd3, 5'd5, 32'h11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    sample();
    chk("rst_ack", bus.commit_ack, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_redirect", bus.redirect_pc, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);

    next_slot();
    rst = 1'b1;
    push_exp(1'b1, 5'd5, 32'h11, 4'd3);
    sample();
    chk("add_ack", bus.commit_ack, 1);

    next_slot();
    drive(OP_ADD, 4'd4, 5'd0, 32'h22, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    push_exp(1'b0, 5'd0, 32'h22, 4'd4);
    sample();
    chk("rd0_ack", bus.commit_ack, 1);

    next_slot();
    bus.commit_valid = 1'b0;
    repeat (2) begin
      sample();
      chk("novalid_ack", bus.commit_ack, 0);
    end

    do_store(OP_SB, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1003, 32'hAB00_0000, 4'b1000, 3);
    do_store(OP_SH, 32'h0000_2003, 32'h1234_CDEF, 32'h0000_2002, 32'hCDEF_0000, 4'b1100, 1);
    do_store(OP_SW, 32'h0000_3001, 32'hDEAD_BEEF, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 2);

    do_branch(OP_BEQ,  5'd0, 32'h0,   4'd1, 32'h100, 32'h180, 32'h180, 1'b1, 1'b0, 1'b1, 32'h104);
    do_branch(OP_JALR, 5'd1, 32'h204, 4'd8, 32'h200, 32'h240, 32'h200, 1'b1, 1'b1, 1'b1, 32'h240);
    do_branch(OP_BNE,  5'd0, 32'h0,   4'd2, 32'h300, 32'h340, 32'h340, 1'b1, 1'b1, 1'b0, 32'h0);
    do_branch(OP_BLT,  5'd0, 32'h0,   4'd3, 32'h400, 32'h440, 32'h440, 1'b0, 1'b0, 1'b0, 32'h0);
    do_branch(OP_JAL,  5'd2, 32'h504, 4'd5, 32'h500, 32'h600, 32'h0,   1'b0, 1'b1, 1'b1, 32'h600);

`ifdef COMMIT_PERF_EN
    chk("perf_retired", perf_retired, 64'(n_retire));
    chk("perf_mispred", {32'd0, perf_mispred}, 64'(n_mis));
`endif

    // Reset while a store is outstanding abandons it without retirement
    next_slot();
    drive(OP_SW, 4'd7, 5'd0, 32'h1, 32'h0, 32'h4000, 32'h0, 1'b0, 1'b0);
    sample();
    next_slot();
    sample();
    chk("rst_sw_req_pre", bus.mem_req, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.mem_done = 1'b1;
    #1;
    chk("rst_sw_req", bus.mem_req, 0);
    chk("rst_sw_ack", bus.commit_ack, 0);
    chk("rst_sw_wmask", bus.mem_wmask, 0);
    chk("rst_sw_addr", bus.mem_addr, 0);
    sample();
    next_slot();
    rst = 1'b1;
    bus.mem_done = 1'b0;
    drive(OP_ADD, 4'd9, 5'd3, 32'h99, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    push_exp(1'b1, 5'd3, 32'h99, 4'd9);
    sample();
    chk("post_rst_ack", bus.commit_ack, 1);
    chk("post_rst_req", bus.mem_req, 0);

    next_slot();
    bus.commit_valid = 1'b0;
    repeat (2) sample();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
